// File: rtl/tact_event.sv
// Multi-channel tactile switch event generator: synchronise, startup-mask and
// debounce raw pins on the Frame tick, then emit press/release/long/repeat pulses.
module tact_chan #(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int LONG_FRAMES     = 60,
  parameter int REPEAT_FRAMES   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sample,
  input  logic repeat_en,
  output logic push,
  output logic rel,
  output logic long_push,
  output logic rpt,
  output logic held
);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int HW = $clog2(LONG_FRAMES + 1);
  localparam int RW = $clog2(REPEAT_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  state_t          state;
  logic            db;
  logic [DW-1:0]   dcnt;
  logic [HW-1:0]   hcnt;
  logic [RW-1:0]   rcnt;
  logic            flip;

  assign flip = tick && (sample != db) && (dcnt == DW'(DEBOUNCE_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      db        <= 1'b0;
      dcnt      <= '0;
      hcnt      <= '0;
      rcnt      <= '0;
      push      <= 1'b0;
      rel       <= 1'b0;
      long_push <= 1'b0;
      rpt       <= 1'b0;
      held      <= 1'b0;
    end else begin
      push      <= 1'b0;
      rel       <= 1'b0;
      long_push <= 1'b0;
      rpt       <= 1'b0;
      if (tick) begin
        if (sample == db)  dcnt <= '0;
        else if (flip) begin
          dcnt <= '0;
          db   <= sample;
        end else           dcnt <= dcnt + 1'b1;

        // a completing release wins over LongPush/Repeat on the same tick
        case (state)
          IDLE: if (flip && sample) begin
            state <= PRESSED;
            push  <= 1'b1;
            held  <= 1'b1;
            hcnt  <= '0;
          end
          PRESSED: if (flip && !sample) begin
            state <= IDLE;
            rel   <= 1'b1;
            held  <= 1'b0;
          end else if (hcnt == HW'(LONG_FRAMES - 1)) begin
            state     <= LONG;
            long_push <= 1'b1;
            hcnt      <= hcnt + 1'b1;
            rcnt      <= '0;
          end else hcnt <= hcnt + 1'b1;
          LONG: if (flip && !sample) begin
            state <= IDLE;
            rel   <= 1'b1;
            held  <= 1'b0;
          end else if (rcnt == RW'(REPEAT_FRAMES - 1)) begin
            rcnt <= '0;
            rpt  <= repeat_en;
          end else rcnt <= rcnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

module tact_event #(
  parameter int NUM_TACT        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int STARTUP_FRAMES  = 16,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int LONG_FRAMES     = 60,
  parameter int REPEAT_FRAMES   = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Frame,
  input  logic [NUM_TACT-1:0] Tact,
  input  logic [NUM_TACT-1:0] RepeatEn,
  output logic [NUM_TACT-1:0] Push,
  output logic [NUM_TACT-1:0] Release,
  output logic [NUM_TACT-1:0] LongPush,
  output logic [NUM_TACT-1:0] Repeat,
  output logic [NUM_TACT-1:0] Held
);
  localparam int   SW      = $clog2(STARTUP_FRAMES + 1);
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  logic [NUM_TACT-1:0] sync1, sync2, pressed;
  logic [SW-1:0]       scnt;
  logic                tick;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= {NUM_TACT{REL_LVL}};
      sync2 <= {NUM_TACT{REL_LVL}};
      scnt  <= '0;
    end else begin
      sync1 <= Tact;
      sync2 <= sync1;
      if (Frame && scnt != SW'(STARTUP_FRAMES)) scnt <= scnt + 1'b1;
    end
  end

  // the tick that saturates the startup count sees scnt one short, so it is masked
  assign tick    = Frame && (scnt == SW'(STARTUP_FRAMES));
  assign pressed = sync2 ^ {NUM_TACT{REL_LVL}};

  for (genvar i = 0; i < NUM_TACT; i++) begin : g_ch
    tact_chan #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
      .LONG_FRAMES    (LONG_FRAMES),
      .REPEAT_FRAMES  (REPEAT_FRAMES)
    ) u_ch (
      .clk      (Clock),
      .rst      (Reset),
      .tick     (tick),
      .sample   (pressed[i]),
      .repeat_en(RepeatEn[i]),
      .push     (Push[i]),
      .rel      (Release[i]),
      .long_push(LongPush[i]),
      .rpt      (Repeat[i]),
      .held     (Held[i])
    );
  end
endmodule

// File: tb/tb_tact_event.sv
// Scoreboard bench for tact_event: stimulus pushes per-cycle expectations from a
// behavioural model, a monitor pops and compares after each rising edge.
module tb_tact_event;
  localparam int N = 4, SF = 16, DB = 3, LF = 60, RF = 8;

  logic         Clock = 1'b0, Reset = 1'b1, Frame = 1'b0;
  logic [N-1:0] Tact = '1, RepeatEn = '0;
  logic [N-1:0] Push, Release, LongPush, Repeat, Held;

  tact_event #(
    .NUM_TACT(N), .ACTIVE_LOW(1), .STARTUP_FRAMES(SF),
    .DEBOUNCE_FRAMES(DB), .LONG_FRAMES(LF), .REPEAT_FRAMES(RF)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Frame(Frame), .Tact(Tact), .RepeatEn(RepeatEn),
    .Push(Push), .Release(Release), .LongPush(LongPush), .Repeat(Repeat), .Held(Held)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [N-1:0] push, rel, lng, rep, held;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;

  // reference model state
  int           nframes;
  logic [N-1:0] d1, d2;
  bit           db[N];
  bit           hist[N][$];
  int           age[N];

  task automatic model_reset();
    nframes = 0; d1 = '0; d2 = '0;
    for (int c = 0; c < N; c++) begin
      db[c] = 1'b0; hist[c].delete(); age[c] = -1;
    end
  endtask

  // Drive one cycle's inputs at a falling edge, predict the outputs after the
  // next rising edge, then advance to the following falling edge.
  task automatic step(input logic [N-1:0] p, input logic frm, input logic [N-1:0] en);
    exp_t e;
    bit   smp, all;
    Tact = ~p; Frame = frm; RepeatEn = en;
    e = '0;
    if (frm && nframes >= SF) begin
      for (int c = 0; c < N; c++) begin
        smp = d2[c];
        hist[c].push_back(smp);
        if (hist[c].size() > DB) void'(hist[c].pop_front());
        all = (hist[c].size() == DB);
        for (int j = 0; j < hist[c].size(); j++) if (hist[c][j] == db[c]) all = 1'b0;
        if (all) begin
          db[c] = smp; hist[c].delete();
          if (smp) begin e.push[c] = 1'b1; age[c] = 0; end
          else     begin e.rel[c]  = 1'b1; age[c] = -1; end
        end else if (age[c] >= 0) begin
          age[c]++;
          if (age[c] == LF) e.lng[c] = 1'b1;
          else if (age[c] > LF && (age[c] - LF) % RF == 0 && en[c]) e.rep[c] = 1'b1;
        end
      end
    end
    if (frm) nframes++;
    for (int c = 0; c < N; c++) e.held[c] = (age[c] >= 0);
    d2 = d1; d1 = p;
    sb.push_back(e);
    @(negedge Clock);
  endtask

  task automatic run(input logic [N-1:0] p, input int cycles, input int fprob, input logic [N-1:0] en);
    repeat (cycles) step(p, $urandom_range(99) < fprob, en);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    tests++;
    if ({Push, Release, LongPush, Repeat, Held} != '0) begin
      fails++;
      $display("FAIL async_reset outputs=%b expected all zero", {Push, Release, LongPush, Repeat, Held});
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    model_reset();
  endtask

  // monitor
  int fcount = 0;
  bit got_push = 1'b0;
  initial begin
    exp_t e, g;
    forever begin
      @(posedge Clock); #1;
      if (Reset) fcount = 0;
      else if (Frame) fcount++;
      if (!got_push && !Reset && Push[0]) begin
        got_push = 1'b1;
        tests++;
        if (fcount != SF + DB) begin
          fails++;
          $display("FAIL startup_push_frame got=%0d expected=%0d", fcount, SF + DB);
        end
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = '{push: Push, rel: Release, lng: LongPush, rep: Repeat, held: Held};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs t=%0t push/rel/lng/rep/held got=%b_%b_%b_%b_%b expected=%b_%b_%b_%b_%b",
                   $time, g.push, g.rel, g.lng, g.rep, g.held, e.push, e.rel, e.lng, e.rep, e.held);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] p, en;
    int guard;
    model_reset();
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    model_reset();

    // startup mask: channel 0 pressed from reset release
    run(4'b0001, 60, 50, '0);
    run(4'b0000, 10, 100, '0);

    // bounce rejection on channel 1, then a clean press
    for (int k = 0; k < 10; k++) run((k % 2) ? 4'b0010 : 4'b0000, 2, 100, '0);
    run(4'b0010, 10, 100, '0);
    run(4'b0000, 8, 100, '0);

    // long press with repeats, release debounce landing on a repeat boundary
    run(4'b0100, 100, 100, '1);
    guard = 0;
    while (!(age[2] > LF && (age[2] + 5 - LF) % RF == 0) && guard < 100) begin
      step(4'b0100, 1'b1, '1);
      guard++;
    end
    tests++;
    if (guard >= 100) begin
      fails++;
      $display("FAIL release_align_timeout guard=%0d expected<100", guard);
    end
    run(4'b0000, 12, 100, '1);

    // RepeatEn low, then raised mid-hold
    run(4'b0100, 90, 100, '0);
    run(4'b0100, 40, 100, 4'b0100);
    run(4'b0000, 10, 100, '0);

    // all channels together with continuous Frame
    run(4'b1111, 12, 100, '1);
    run(4'b0000, 8, 100, '1);

    // reset while channel 3 is long-held, then startup mask again
    run(4'b1000, 75, 100, '0);
    do_reset();
    run(4'b1000, 40, 100, '0);
    run(4'b0000, 10, 100, '0);

    // randomized per-channel holds and bounces
    p = '0; en = '1;
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(99) < ((c == 0) ? 8 : (c == 1) ? 3 : 1)) p[c] = ~p[c];
      if ($urandom_range(199) == 0) en = N'($urandom);
      step(p, $urandom_range(99) < 75, en);
    end

    @(posedge Clock); #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
